// File: rtl/autoconfig_chain.sv
// autoconfig_chain: Zorro II AutoConfig engine offering a chain of logical boards.
// Optional: `define ACFG_BASE_READBACK_EN to read base back at indexes 24h/25h.
module autoconfig_chain #(
  parameter int                      NUM_BOARDS = 3,
  parameter logic [NUM_BOARDS*8-1:0] ER_TYPE    = {8'hC1, 8'hC1, 8'hE5},
  parameter logic [NUM_BOARDS*8-1:0] PRODUCT    = {8'h0A, 8'h09, 8'h08},
  parameter logic [NUM_BOARDS*8-1:0] MATCH_MASK = {8'hFF, 8'hFF, 8'hF0},
  parameter logic [15:0]             MFG_ID     = 16'h07DB,
  parameter logic [31:0]             SERIAL     = 32'h0000_0001,
  parameter int                      DTACK_WAIT = 4
) (
  input  logic                  CPU_CLK,
  input  logic                  RESET,
  input  logic                  CPU_AS,
  input  logic                  UDS,
  input  logic                  LDS,
  input  logic                  RW,
  input  logic [23:1]           ADDRESS,
  input  logic [3:0]            DATA_IN,
  output logic [3:0]            DATA_OUT,
  output logic                  DATA_OE,
  output logic                  CPU_DTACK,
  output logic [NUM_BOARDS-1:0] BOARD_HIT,
  output logic [NUM_BOARDS-1:0] CONFIGURED,
  output logic                  ALL_DONE
);

  localparam int CW = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_WAIT, S_ACK, S_HOLD
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic as_m_q, as_s_q, ds_m_q, ds_s_q;
  logic [CW-1:0] cur_q, cur_c;
  logic [6:0] idx_q;
  logic rw_q;
  logic [7:0] base_q [NUM_BOARDS];
  logic [NUM_BOARDS-1:0] cfg_q, shut_q;
  logic free_c, win_c;
  logic [7:0] er_c, pr_c;
  logic [2:0] sidx_c;
  logic [3:0] nib_c, rb_c;
  logic rb_sel_c;
  logic [7:0] unused_addr;

  assign unused_addr = ADDRESS[15:8];

  // Lowest-index board still waiting to be configured.
  always_comb begin
    cur_c  = '0;
    free_c = 1'b0;
    for (int i = NUM_BOARDS - 1; i >= 0; i--) begin
      if (!cfg_q[i] && !shut_q[i]) begin
        cur_c  = CW'(i);
        free_c = 1'b1;
      end
    end
  end

  assign ALL_DONE   = !free_c;
  assign CONFIGURED = cfg_q;
  assign win_c      = (ADDRESS[23:16] == 8'hE8) && free_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (!as_s_q && !ds_s_q && win_c) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (as_s_q) begin
          state_d = S_IDLE;
        end else if (DTACK_WAIT == 1) begin
          state_d = S_ACK;
        end else begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (as_s_q) state_d = S_IDLE;
        else if (cnt_q == 4'(DTACK_WAIT - 2)) state_d = S_ACK;
        else cnt_d = cnt_q + 4'd1;
      end
      S_ACK:   state_d = S_HOLD;
      S_HOLD: begin
        if (as_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CPU_CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      as_m_q  <= 1'b1;
      as_s_q  <= 1'b1;
      ds_m_q  <= 1'b1;
      ds_s_q  <= 1'b1;
      cur_q   <= '0;
      idx_q   <= '0;
      rw_q    <= 1'b0;
      cfg_q   <= '0;
      shut_q  <= '0;
      for (int i = 0; i < NUM_BOARDS; i++) base_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      as_m_q  <= CPU_AS;
      as_s_q  <= as_m_q;
      ds_m_q  <= UDS & LDS;
      ds_s_q  <= ds_m_q;
      if (state_q == S_IDLE && state_d == S_DECODE) begin
        cur_q <= cur_c;
        idx_q <= ADDRESS[7:1];
        rw_q  <= RW;
      end
      if (state_q == S_ACK && !rw_q) begin
        case (idx_q)
          7'h25: base_q[cur_q][3:0] <= DATA_IN;
          7'h24: begin
            base_q[cur_q][7:4] <= DATA_IN;
            cfg_q[cur_q]       <= 1'b1;
          end
          7'h26: shut_q[cur_q] <= 1'b1;
          default: ;
        endcase
      end
    end
  end

`ifdef ACFG_BASE_READBACK_EN
  assign rb_sel_c = (idx_q == 7'h24) || (idx_q == 7'h25);
  assign rb_c     = idx_q[0] ? base_q[cur_q][3:0] : base_q[cur_q][7:4];
`else
  assign rb_sel_c = 1'b0;
  assign rb_c     = 4'hF;
`endif

  assign er_c   = ER_TYPE[8*cur_q +: 8];
  assign pr_c   = PRODUCT[8*cur_q +: 8];
  assign sidx_c = 3'(idx_q - 7'h0C);

  // ROM nibbles other than ER_TYPE are stored inverted on the bus.
  always_comb begin
    nib_c = 4'hF;
    unique case (1'b1)
      (idx_q == 7'h00): nib_c = er_c[7:4];
      (idx_q == 7'h01): nib_c = er_c[3:0];
      (idx_q == 7'h02): nib_c = ~pr_c[7:4];
      (idx_q == 7'h03): nib_c = ~pr_c[3:0];
      (idx_q inside {[7'h08:7'h0B]}):
        nib_c = 4'(~MFG_ID >> {~idx_q[1:0], 2'b00});
      (idx_q inside {[7'h0C:7'h13]}):
        nib_c = 4'(~SERIAL >> {~sidx_c, 2'b00});
      default: nib_c = rb_sel_c ? rb_c : 4'hF;
    endcase
  end

  always_comb begin
    DATA_OE   = rw_q && (state_q != S_IDLE)
                && !(state_q == S_HOLD && as_s_q);
    DATA_OUT  = DATA_OE ? nib_c : 4'hF;
    CPU_DTACK = !((state_q == S_ACK)
                  || (state_q == S_HOLD && !as_s_q));
  end

  always_comb begin
    BOARD_HIT = '0;
    for (int i = 0; i < NUM_BOARDS; i++) begin
      BOARD_HIT[i] = cfg_q[i] && !CPU_AS && !(UDS & LDS)
        && (((ADDRESS[23:16] ^ base_q[i]) & MATCH_MASK[8*i +: 8]) == 8'h00);
    end
  end

endmodule
